lsu_ddr3_responder: RTL and testbench
=====================================

Name: lsu_ddr3_responder

Overview:
- Memory-side end of the LSU-to-DDR3 request handshake.
- Accepts single-beat read/write requests from the LSU output stage, forwards each one to the DDR3 backing interface, and signals completion.
- Completion is signalled by raising DDR3_rdy (read) or DDR3_w_rdy (write); the LSU-side stall controller detects completion as a 0->1 edge, sampled only in cycles where stall_i=0.
- Sits between the LSU output register and the DDR3 controller port, with a one-entry pending buffer.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, data width
- RESP_HOLD, 2, number of non-stalled cycles a ready output stays high (>=1)
- TIMEOUT, 255, cycles in WAIT_ACK before the timeout path fires (used only with the optional feature)

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-low reset
- stall_i  in  1  pipeline stall (same signal the LSU side sees)
- LSUOut2DDR3_en  in  1  request strobe, one cycle per request
- LSUOut2DDR3_we  in  1  1=write, 0=read
- LSUOut2DDR3_addr  in  ADDR_W  request address
- LSUOut2DDR3_wdata  in  DATA_W  write data
- mem_req  out  1  request to DDR3 controller, held until mem_ack
- mem_we  out  1  write enable to DDR3 controller
- mem_addr  out  ADDR_W  address to DDR3 controller
- mem_wdata  out  DATA_W  write data to DDR3 controller
- mem_ack  in  1  controller done, single-cycle pulse
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- DDR3_rdy  out  1  read-complete indication
- DDR3_w_rdy  out  1  write-complete indication
- DDR3_rdata  out  DATA_W  read data, valid while DDR3_rdy=1
- overrun_o  out  1  sticky: a request was dropped
- busy_o  out  1  FSM not in IDLE, or the pending buffer is full

Behaviour:
- Reset (reset=0 at posedge):
  - all outputs 0, including the sticky flag
  - FSM goes to IDLE; pending buffer emptied; hold counter cleared
  - reset mid-transaction aborts it; a late mem_ack after reset is ignored in IDLE
- Request capture:
  - Accepted on any posedge with LSUOut2DDR3_en=1, regardless of stall_i.
  - In IDLE, the request is latched into the active registers and the FSM goes to ISSUE.
  - Otherwise it goes to the pending buffer if that buffer is empty.
  - If the buffer is full, the request is dropped and overrun_o is set to 1 (sticky until reset).
- FSM states:
  - IDLE: if the pending buffer is valid, move its contents to the active registers, clear the buffer, go to ISSUE. A new strobe in the same cycle goes into the now-empty buffer.
  - ISSUE: drive mem_req=1 with active we/addr/wdata next cycle; go to WAIT_ACK. Latency from strobe to mem_req = 2 cycles.
  - WAIT_ACK: hold mem_req and mem_* stable. On mem_ack:
    - drop mem_req the next cycle
    - for a read, capture mem_rdata into DDR3_rdata
    - go to RESP
  - RESP:
    - Assert DDR3_rdy (read) or DDR3_w_rdy (write); exactly one is high, never both.
    - The hold counter increments only on cycles with stall_i=0.
    - When the counter reaches RESP_HOLD, deassert and go to GAP.
    - While stall_i=1 the output stays high indefinitely.
  - GAP: both ready outputs 0. Stay until one cycle with stall_i=0 has elapsed, then go to IDLE. This guarantees the LSU-side sampler sees the low level before the next rising edge.
- DDR3_rdata holds its value until the next read completes.
- busy_o is combinational from state and buffer valid.
- A strobe in the same cycle as mem_ack goes to the buffer (or is dropped if the buffer is full), never to the active registers.

Optional Feature:
- Macro DDR3_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACK.
  - When it reaches TIMEOUT with no mem_ack, the FSM drops mem_req, sets output port timeout_o (1 bit, sticky until reset), and goes to RESP as a normal completion with DDR3_rdata=0.
  - This prevents the LSU from hanging.
- Undefined: no counter and no timeout_o port; WAIT_ACK waits forever.

Test Plan:
- Read, no stall: strobe with we=0, addr=0x100, mem_ack 3 cycles after mem_req with rdata=0xDEADBEEF -> mem_req rises 2 cycles after the strobe; DDR3_rdy high for 2 cycles with DDR3_rdata=0xDEADBEEF; DDR3_w_rdy stays 0.
- Write under stall: write to 0x40, stall_i=1 from mem_ack until 5 cycles later -> DDR3_w_rdy stays high through the stall, then for 2 more cycles after stall_i falls; GAP lasts 1 non-stalled cycle.
- Back-to-back: second strobe while the first is in WAIT_ACK -> buffered; issued right after GAP; two separate rising edges; overrun_o=0.
- Overrun: three strobes while busy -> third dropped; overrun_o=1 and stays 1; only two mem_req transactions occur.
- Reset mid-op: reset=0 during WAIT_ACK, then mem_ack arrives -> all outputs 0, FSM in IDLE, no ready pulse.
- DDR3_TIMEOUT_EN with TIMEOUT=8 and no mem_ack -> mem_req drops 8 cycles after entering WAIT_ACK; timeout_o=1; DDR3_rdy pulses with DDR3_rdata=0.

Source files
------------

// File: rtl/lsu_ddr3_responder_if.sv
// ----------------------------------------------------------------------------
// lsu_ddr3_responder_if
//   Groups the three buses around the LSU-to-DDR3 responder:
//     - LSU request   : LSUOut2DDR3_en/_we/_addr/_wdata (LSU -> responder)
//     - DDR3 backing  : mem_req/_we/_addr/_wdata (responder -> controller),
//                       mem_ack/_rdata (controller -> responder)
//     - completion    : DDR3_rdy, DDR3_w_rdy, DDR3_rdata (responder -> LSU)
//   Modports:
//     slave  : the responder itself
//     master : the LSU / DDR3 controller side (bench or surrounding fabric)
// ----------------------------------------------------------------------------
interface lsu_ddr3_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              LSUOut2DDR3_en;
    logic              LSUOut2DDR3_we;
    logic [ADDR_W-1:0] LSUOut2DDR3_addr;
    logic [DATA_W-1:0] LSUOut2DDR3_wdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              DDR3_rdy;
    logic              DDR3_w_rdy;
    logic [DATA_W-1:0] DDR3_rdata;

    modport slave (
        input  LSUOut2DDR3_en, LSUOut2DDR3_we, LSUOut2DDR3_addr, LSUOut2DDR3_wdata,
        input  mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output DDR3_rdy, DDR3_w_rdy, DDR3_rdata
    );

    modport master (
        output LSUOut2DDR3_en, LSUOut2DDR3_we, LSUOut2DDR3_addr, LSUOut2DDR3_wdata,
        output mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  DDR3_rdy, DDR3_w_rdy, DDR3_rdata
    );
endinterface

// File: rtl/lsu_ddr3_responder.sv
// ----------------------------------------------------------------------------
// lsu_ddr3_responder
//   Memory-side end of the LSU-to-DDR3 handshake. Each single-beat request
//   strobed by the LSU is forwarded to the DDR3 controller (mem_req held until
//   mem_ack); completion is reported as a level on DDR3_rdy (read) or
//   DDR3_w_rdy (write) that stays high for RESP_HOLD non-stalled cycles,
//   followed by a low GAP so the LSU-side edge detector (which samples only
//   when stall_i=0) always sees a fresh 0->1 edge. A one-entry pending buffer
//   absorbs a request that arrives while a transaction is in flight.
//
// Ports:
//   clk       : clock, all logic on posedge
//   reset     : synchronous active-low reset
//   stall_i   : pipeline stall, gates the completion hold/gap counting
//   bus       : lsu_ddr3_responder_if.slave (LSU request, DDR3 bus, completion)
//   overrun_o : sticky, a request was dropped because the buffer was full
//   busy_o    : FSM not in IDLE or pending buffer occupied (combinational)
//   timeout_o : sticky, WAIT_ACK gave up after TIMEOUT cycles
//               (present only when DDR3_TIMEOUT_EN is defined)
//
// Build option:
//   DDR3_TIMEOUT_EN : adds the WAIT_ACK watchdog and the timeout_o port.
//                     Without it WAIT_ACK waits for mem_ack indefinitely.
// ----------------------------------------------------------------------------
module lsu_ddr3_responder #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RESP_HOLD = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_i,
    lsu_ddr3_responder_if.slave     bus,
    output logic                    overrun_o,
    output logic                    busy_o
`ifdef DDR3_TIMEOUT_EN
   ,output logic                    timeout_o
`endif
);

    if (RESP_HOLD < 1 || TIMEOUT < 1) begin : g_param_check
        $error("lsu_ddr3_responder: RESP_HOLD and TIMEOUT must both be >= 1");
    end

    localparam int HOLD_W = $clog2(RESP_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_RESP,
        S_GAP
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_e            state_q,    state_d;
    req_t              act_q,      act_d;      // request being serviced
    req_t              pend_q,     pend_d;     // one-entry pending buffer
    logic              pend_vld_q, pend_vld_d;
    logic              mem_req_q,  mem_req_d;
    logic              rdy_q,      rdy_d;
    logic              w_rdy_q,    w_rdy_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic              overrun_q,  overrun_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

`ifdef DDR3_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]  tmo_cnt_q,  tmo_cnt_d;
    logic              timeout_q,  timeout_d;
`endif

    req_t in_req;
    logic strobe_to_act;   // this cycle's strobe was consumed by IDLE directly

    assign in_req = '{we:    bus.LSUOut2DDR3_we,
                      addr:  bus.LSUOut2DDR3_addr,
                      wdata: bus.LSUOut2DDR3_wdata};

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case leaves it unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        act_d         = act_q;
        pend_d        = pend_q;
        pend_vld_d    = pend_vld_q;
        mem_req_d     = mem_req_q;
        rdy_d         = rdy_q;
        w_rdy_d       = w_rdy_q;
        rdata_d       = rdata_q;
        overrun_d     = overrun_q;
        hold_cnt_d    = hold_cnt_q;
        strobe_to_act = 1'b0;
`ifdef DDR3_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_d     = timeout_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                // A buffered request has priority over a fresh strobe; the
                // strobe then lands in the buffer freed this same cycle.
                if (pend_vld_q) begin
                    act_d      = pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = S_ISSUE;
                end else if (bus.LSUOut2DDR3_en) begin
                    act_d         = in_req;
                    strobe_to_act = 1'b1;
                    state_d       = S_ISSUE;
                end
            end

            S_ISSUE: begin
                mem_req_d = 1'b1;
                state_d   = S_WAIT_ACK;
`ifdef DDR3_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end

            S_WAIT_ACK: begin
                if (bus.mem_ack) begin
                    mem_req_d  = 1'b0;
                    if (!act_q.we) rdata_d = bus.mem_rdata;
                    rdy_d      = !act_q.we;
                    w_rdy_d    = act_q.we;
                    hold_cnt_d = '0;
                    state_d    = S_RESP;
                end
`ifdef DDR3_TIMEOUT_EN
                // Give up and complete normally so the LSU never hangs; a read
                // returns zero data.
                else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    mem_req_d  = 1'b0;
                    timeout_d  = 1'b1;
                    if (!act_q.we) rdata_d = '0;
                    rdy_d      = !act_q.we;
                    w_rdy_d    = act_q.we;
                    hold_cnt_d = '0;
                    state_d    = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            S_RESP: begin
                // Only non-stalled cycles count, since the LSU side samples
                // the ready level only when stall_i=0.
                if (!stall_i) begin
                    if (hold_cnt_q == HOLD_W'(RESP_HOLD - 1)) begin
                        rdy_d      = 1'b0;
                        w_rdy_d    = 1'b0;
                        hold_cnt_d = '0;
                        state_d    = S_GAP;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end

            S_GAP: begin
                // One non-stalled low cycle lets the sampler see 0 before the
                // next completion raises the ready again.
                if (!stall_i) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Any strobe not taken straight into the active registers goes to the
        // pending buffer, or is dropped when the buffer is still occupied.
        if (bus.LSUOut2DDR3_en && !strobe_to_act) begin
            if (!pend_vld_d) begin
                pend_d     = in_req;
                pend_vld_d = 1'b1;
            end else begin
                overrun_d  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (!reset) begin
            // Data registers are cleared too: they drive outputs that must
            // read zero after reset.
            state_q    <= S_IDLE;
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            mem_req_q  <= 1'b0;
            rdy_q      <= 1'b0;
            w_rdy_q    <= 1'b0;
            rdata_q    <= '0;
            overrun_q  <= 1'b0;
            hold_cnt_q <= '0;
`ifdef DDR3_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            mem_req_q  <= mem_req_d;
            rdy_q      <= rdy_d;
            w_rdy_q    <= w_rdy_d;
            rdata_q    <= rdata_d;
            overrun_q  <= overrun_d;
            hold_cnt_q <= hold_cnt_d;
`ifdef DDR3_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = act_q.we;
    assign bus.mem_addr   = act_q.addr;
    assign bus.mem_wdata  = act_q.wdata;
    assign bus.DDR3_rdy   = rdy_q;
    assign bus.DDR3_w_rdy = w_rdy_q;
    assign bus.DDR3_rdata = rdata_q;
    assign overrun_o      = overrun_q;
    assign busy_o         = (state_q != S_IDLE) || pend_vld_q;
`ifdef DDR3_TIMEOUT_EN
    assign timeout_o      = timeout_q;
`endif

endmodule

// File: tb/tb_lsu_ddr3_responder.sv
// ----------------------------------------------------------------------------
// tb_lsu_ddr3_responder
//   Per-cycle vector table: each record holds the inputs applied on one
//   negedge and the outputs expected just after the following posedge.
//   Hand-written sequences follow for the strobe-with-ack corner and, when
//   DDR3_TIMEOUT_EN is defined, the watchdog path (TIMEOUT=8).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_ddr3_responder;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic stall;
    logic overrun;
    logic busy;
`ifdef DDR3_TIMEOUT_EN
    logic timeout;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lsu_ddr3_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    lsu_ddr3_responder #(
        .ADDR_W(AW), .DATA_W(DW), .RESP_HOLD(2), .TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .stall_i   (stall),
        .bus       (bus),
        .overrun_o (overrun),
        .busy_o    (busy)
`ifdef DDR3_TIMEOUT_EN
       ,.timeout_o (timeout)
`endif
    );

    typedef struct {
        logic [63:0] tag;
        // inputs
        logic        rst_n, stall, en, we;
        logic [31:0] addr, wdata;
        logic        ack;
        logic [31:0] mrdata;
        // expected outputs after the edge
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        logic        e_rdy, e_wrdy;
        logic [31:0] e_rdata;
        logic        e_ovr, e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    function automatic void add(input logic [63:0] tag,
                                input logic r, s, en, we, input logic [31:0] a, wd,
                                input logic ack, input logic [31:0] mrd,
                                input logic e_req, e_we, input logic [31:0] e_a, e_wd,
                                input logic e_rdy, e_wrdy, input logic [31:0] e_rd,
                                input logic e_ovr, e_busy);
        vec_t v;
        v.tag = tag; v.rst_n = r; v.stall = s; v.en = en; v.we = we;
        v.addr = a; v.wdata = wd; v.ack = ack; v.mrdata = mrd;
        v.e_req = e_req; v.e_we = e_we; v.e_addr = e_a; v.e_wdata = e_wd;
        v.e_rdy = e_rdy; v.e_wrdy = e_wrdy; v.e_rdata = e_rd;
        v.e_ovr = e_ovr; v.e_busy = e_busy;
        vecs.push_back(v);
    endfunction

    task automatic drive_idle();
        bus.LSUOut2DDR3_en    = 1'b0;
        bus.LSUOut2DDR3_we    = 1'b0;
        bus.LSUOut2DDR3_addr  = '0;
        bus.LSUOut2DDR3_wdata = '0;
        bus.mem_ack           = 1'b0;
        bus.mem_rdata         = '0;
    endtask

    // Waits (after the current edge) until the chosen output equals val.
    // sel: 0 = mem_req, 1 = busy_o. n returns the number of edges seen.
    task automatic wait_for(input int sel, input logic val, input int budget,
                            output int n, output logic ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            n++;
            drive_idle();
            if ((sel == 0 ? bus.mem_req : busy) == val) ok = 1'b1;
        end
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] CF = 32'hCAFEF00D;
    localparam logic [31:0] BC = 32'h0BADC0DE;
    localparam logic [31:0] A5 = 32'hA5A5A5A5;

    initial begin
        int   n;
        logic ok;

        rst_n = 1'b0;
        stall = 1'b0;
        drive_idle();

        //   tag    rst stl en we addr    wdata ack mrdata         req we addr    wdata rdy wrdy rdata ovr busy
        // reset
        add("R0",   0, 0, 0, 0, 0,      0,    0, 0,              0, 0, 0,      0,    0, 0, 0,  0, 0);
        add("R1",   0, 0, 0, 0, 0,      0,    0, 0,              0, 0, 0,      0,    0, 0, 0,  0, 0);
        // read, no stall, ack 3 cycles after mem_req
        add("A0",   1, 0, 1, 0, 'h100,  0,    0, 0,              0, 0, 'h100,  0,    0, 0, 0,  0, 1);
        add("A1",   1, 0, 0, 0, 0,      0,    0, 0,              1, 0, 'h100,  0,    0, 0, 0,  0, 1);
        add("A2",   1, 0, 0, 0, 0,      0,    0, 0,              1, 0, 'h100,  0,    0, 0, 0,  0, 1);
        add("A3",   1, 0, 0, 0, 0,      0,    0, 0,              1, 0, 'h100,  0,    0, 0, 0,  0, 1);
        add("A4",   1, 0, 0, 0, 0,      0,    1, DB,             0, 0, 'h100,  0,    1, 0, DB, 0, 1);
        add("A5",   1, 0, 0, 0, 0,      0,    0, 'h12345678,     0, 0, 'h100,  0,    1, 0, DB, 0, 1);
        add("A6",   1, 0, 0, 0, 0,      0,    0, 0,              0, 0, 'h100,  0,    0, 0, DB, 0, 1);
        add("A7",   1, 0, 0, 0, 0,      0,    0, 0,              0, 0, 'h100,  0,    0, 0, DB, 0, 0);
        // write, stall from mem_ack for 5 cycles
        add("B0",   1, 0, 1, 1, 'h40,   CF,   0, 0,              0, 1, 'h40,   CF,   0, 0, DB, 0, 1);
        add("B1",   1, 0, 0, 0, 0,      0,    0, 0,              1, 1, 'h40,   CF,   0, 0, DB, 0, 1);
        add("B2",   1, 1, 0, 0, 0,      0,    1, 'h0BADBAD0,     0, 1, 'h40,   CF,   0, 1, DB, 0, 1);
        add("B3",   1, 1, 0, 0, 0,      0,    0, 0,              0, 1, 'h40,   CF,   0, 1, DB, 0, 1);
        add("B4",   1, 1, 0, 0, 0,      0,    0, 0,              0, 1, 'h40,   CF,   0, 1, DB, 0, 1);
        add("B5",   1, 1, 0, 0, 0,      0,    0, 0,              0, 1, 'h40,   CF,   0, 1, DB, 0, 1);
        add("B6",   1, 1, 0, 0, 0,      0,    0, 0,              0, 1, 'h40,   CF,   0, 1, DB, 0, 1);
        add("B7",   1, 0, 0, 0, 0,      0,    0, 0,              0, 1, 'h40,   CF,   0, 1, DB, 0, 1);
        add("B8",   1, 0, 0, 0, 0,      0,    0, 0,              0, 1, 'h40,   CF,   0, 0, DB, 0, 1);
        add("B9",   1, 1, 0, 0, 0,      0,    0, 0,              0, 1, 'h40,   CF,   0, 0, DB, 0, 1);
        add("B10",  1, 1, 0, 0, 0,      0,    0, 0,              0, 1, 'h40,   CF,   0, 0, DB, 0, 1);
        add("B11",  1, 0, 0, 0, 0,      0,    0, 0,              0, 1, 'h40,   CF,   0, 0, DB, 0, 0);
        // back-to-back: second strobe buffered during WAIT_ACK
        add("C0",   1, 0, 1, 0, 'h200,  0,    0, 0,              0, 0, 'h200,  0,    0, 0, DB, 0, 1);
        add("C1",   1, 0, 0, 0, 0,      0,    0, 0,              1, 0, 'h200,  0,    0, 0, DB, 0, 1);
        add("C2",   1, 0, 1, 1, 'h300,  BC,   0, 0,              1, 0, 'h200,  0,    0, 0, DB, 0, 1);
        add("C3",   1, 0, 0, 0, 0,      0,    1, A5,             0, 0, 'h200,  0,    1, 0, A5, 0, 1);
        add("C4",   1, 0, 0, 0, 0,      0,    0, 0,              0, 0, 'h200,  0,    1, 0, A5, 0, 1);
        add("C5",   1, 0, 0, 0, 0,      0,    0, 0,              0, 0, 'h200,  0,    0, 0, A5, 0, 1);
        add("C6",   1, 0, 0, 0, 0,      0,    0, 0,              0, 0, 'h200,  0,    0, 0, A5, 0, 1);
        add("C7",   1, 0, 0, 0, 0,      0,    0, 0,              0, 1, 'h300,  BC,   0, 0, A5, 0, 1);
        add("C8",   1, 0, 0, 0, 0,      0,    0, 0,              1, 1, 'h300,  BC,   0, 0, A5, 0, 1);
        add("C9",   1, 0, 0, 0, 0,      0,    1, 0,              0, 1, 'h300,  BC,   0, 1, A5, 0, 1);
        add("C10",  1, 0, 0, 0, 0,      0,    0, 0,              0, 1, 'h300,  BC,   0, 1, A5, 0, 1);
        add("C11",  1, 0, 0, 0, 0,      0,    0, 0,              0, 1, 'h300,  BC,   0, 0, A5, 0, 1);
        add("C12",  1, 0, 0, 0, 0,      0,    0, 0,              0, 1, 'h300,  BC,   0, 0, A5, 0, 0);
        // overrun: third strobe dropped, only two transactions follow
        add("D0",   1, 0, 1, 0, 'h10,   0,    0, 0,              0, 0, 'h10,   0,    0, 0, A5, 0, 1);
        add("D1",   1, 0, 1, 1, 'h20,   'h22, 0, 0,              1, 0, 'h10,   0,    0, 0, A5, 0, 1);
        add("D2",   1, 0, 1, 0, 'h30,   0,    0, 0,              1, 0, 'h10,   0,    0, 0, A5, 1, 1);
        add("D3",   1, 0, 0, 0, 0,      0,    1, 'h55,           0, 0, 'h10,   0,    1, 0, 'h55, 1, 1);
        add("D4",   1, 0, 0, 0, 0,      0,    0, 0,              0, 0, 'h10,   0,    1, 0, 'h55, 1, 1);
        add("D5",   1, 0, 0, 0, 0,      0,    0, 0,              0, 0, 'h10,   0,    0, 0, 'h55, 1, 1);
        add("D6",   1, 0, 0, 0, 0,      0,    0, 0,              0, 0, 'h10,   0,    0, 0, 'h55, 1, 1);
        add("D7",   1, 0, 0, 0, 0,      0,    0, 0,              0, 1, 'h20,   'h22, 0, 0, 'h55, 1, 1);
        add("D8",   1, 0, 0, 0, 0,      0,    0, 0,              1, 1, 'h20,   'h22, 0, 0, 'h55, 1, 1);
        add("D9",   1, 0, 0, 0, 0,      0,    1, 0,              0, 1, 'h20,   'h22, 0, 1, 'h55, 1, 1);
        add("D10",  1, 0, 0, 0, 0,      0,    0, 0,              0, 1, 'h20,   'h22, 0, 1, 'h55, 1, 1);
        add("D11",  1, 0, 0, 0, 0,      0,    0, 0,              0, 1, 'h20,   'h22, 0, 0, 'h55, 1, 1);
        add("D12",  1, 0, 0, 0, 0,      0,    0, 0,              0, 1, 'h20,   'h22, 0, 0, 'h55, 1, 0);
        add("D13",  1, 0, 0, 0, 0,      0,    0, 0,              0, 1, 'h20,   'h22, 0, 0, 'h55, 1, 0);
        add("D14",  1, 0, 0, 0, 0,      0,    0, 0,              0, 1, 'h20,   'h22, 0, 0, 'h55, 1, 0);
        // reset during WAIT_ACK, late mem_ack ignored
        add("E0",   1, 0, 1, 0, 'h80,   0,    0, 0,              0, 0, 'h80,   0,    0, 0, 'h55, 1, 1);
        add("E1",   1, 0, 0, 0, 0,      0,    0, 0,              1, 0, 'h80,   0,    0, 0, 'h55, 1, 1);
        add("E2",   0, 0, 0, 0, 0,      0,    0, 0,              0, 0, 0,      0,    0, 0, 0,  0, 0);
        add("E3",   1, 0, 0, 0, 0,      0,    1, 'h77,           0, 0, 0,      0,    0, 0, 0,  0, 0);
        add("E4",   1, 0, 0, 0, 0,      0,    0, 0,              0, 0, 0,      0,    0, 0, 0,  0, 0);
        add("E5",   1, 0, 0, 0, 0,      0,    0, 0,              0, 0, 0,      0,    0, 0, 0,  0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n                 = vecs[i].rst_n;
            stall                 = vecs[i].stall;
            bus.LSUOut2DDR3_en    = vecs[i].en;
            bus.LSUOut2DDR3_we    = vecs[i].we;
            bus.LSUOut2DDR3_addr  = vecs[i].addr;
            bus.LSUOut2DDR3_wdata = vecs[i].wdata;
            bus.mem_ack           = vecs[i].ack;
            bus.mem_rdata         = vecs[i].mrdata;
            @(posedge clk); #1;
            check($sformatf("%0s.mem_req",   vecs[i].tag), 32'(bus.mem_req),    32'(vecs[i].e_req));
            check($sformatf("%0s.mem_we",    vecs[i].tag), 32'(bus.mem_we),     32'(vecs[i].e_we));
            check($sformatf("%0s.mem_addr",  vecs[i].tag), bus.mem_addr,        vecs[i].e_addr);
            check($sformatf("%0s.mem_wdata", vecs[i].tag), bus.mem_wdata,       vecs[i].e_wdata);
            check($sformatf("%0s.DDR3_rdy",  vecs[i].tag), 32'(bus.DDR3_rdy),   32'(vecs[i].e_rdy));
            check($sformatf("%0s.DDR3_w_rdy",vecs[i].tag), 32'(bus.DDR3_w_rdy), 32'(vecs[i].e_wrdy));
            check($sformatf("%0s.DDR3_rdata",vecs[i].tag), bus.DDR3_rdata,      vecs[i].e_rdata);
            check($sformatf("%0s.overrun",   vecs[i].tag), 32'(overrun),        32'(vecs[i].e_ovr));
            check($sformatf("%0s.busy",      vecs[i].tag), 32'(busy),           32'(vecs[i].e_busy));
        end

        // ---- F: strobe in the same cycle as mem_ack must go to the buffer ----
        @(negedge clk);
        drive_idle();
        stall = 1'b0;
        bus.LSUOut2DDR3_en   = 1'b1;
        bus.LSUOut2DDR3_addr = 'h500;
        wait_for(0, 1'b1, 10, n, ok);
        check("F.req_seen", 32'(ok), 32'd1);
        check("F.req_latency", n, 2);

        @(negedge clk);
        bus.mem_ack           = 1'b1;
        bus.mem_rdata         = 'h99;
        bus.LSUOut2DDR3_en    = 1'b1;
        bus.LSUOut2DDR3_we    = 1'b1;
        bus.LSUOut2DDR3_addr  = 'h600;
        bus.LSUOut2DDR3_wdata = 'h66;
        @(posedge clk); #1;
        drive_idle();
        check("F.ack_addr_kept", bus.mem_addr, 'h500);
        check("F.ack_mem_req",   32'(bus.mem_req), 32'd0);
        check("F.ack_rdy",       32'(bus.DDR3_rdy), 32'd1);
        check("F.ack_rdata",     bus.DDR3_rdata, 'h99);

        wait_for(0, 1'b1, 20, n, ok);
        check("F.buf_req_seen", 32'(ok), 32'd1);
        check("F.buf_addr",     bus.mem_addr, 'h600);
        check("F.buf_we",       32'(bus.mem_we), 32'd1);
        check("F.buf_wdata",    bus.mem_wdata, 'h66);
        check("F.buf_rdy_low",  32'(bus.DDR3_rdy), 32'd0);

        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        check("F.w_rdy", 32'(bus.DDR3_w_rdy), 32'd1);
        wait_for(1, 1'b0, 20, n, ok);
        check("F.idle_seen", 32'(ok), 32'd1);
        check("F.overrun",   32'(overrun), 32'd0);
        check("F.rdata_kept", bus.DDR3_rdata, 'h99);

`ifdef DDR3_TIMEOUT_EN
        // ---- G: no mem_ack, watchdog completes the read with zero data ----
        check("G.timeout_pre", 32'(timeout), 32'd0);
        @(negedge clk);
        bus.LSUOut2DDR3_en   = 1'b1;
        bus.LSUOut2DDR3_addr = 'h700;
        wait_for(0, 1'b1, 10, n, ok);
        check("G.req_seen", 32'(ok), 32'd1);
        wait_for(0, 1'b0, 50, n, ok);
        check("G.req_dropped", 32'(ok), 32'd1);
        check("G.wait_cycles", n, 8);
        check("G.timeout",     32'(timeout), 32'd1);
        check("G.rdy",         32'(bus.DDR3_rdy), 32'd1);
        check("G.rdata_zero",  bus.DDR3_rdata, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
